// File: rtl/maxpool_window_tracker.sv
// maxpool_window_tracker
// Raster position tracker for a max-pooling stage. It counts accepted pixels
// of one frame and reports the column and row of the next pixel, its phase
// inside the pooling window, and same-cycle open/close tags for the
// compare/accumulate datapath. After the last pixel it parks in a done state
// and flags any further pixel strobes as an overrun.
module maxpool_window_tracker #(
  parameter int ROW_LEN   = 100,
  parameter int NUM_ROWS  = 100,
  parameter int POOL_W    = 2,
  parameter int POOL_H    = 2,
  parameter int CEIL_MODE = 0,
  parameter int IDX_W     = 7,
  parameter int PH_W      = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clear,
  output logic [IDX_W-1:0] Col_Idx,
  output logic [IDX_W-1:0] Row_Idx,
  output logic [PH_W-1:0]  Col_Phase,
  output logic [PH_W-1:0]  Row_Phase,
  output logic             Win_First,
  output logic             Win_Last,
  output logic             Frame_Done,
  output logic             Overrun
);

  localparam logic [IDX_W-1:0] COL_MAX  = IDX_W'(ROW_LEN - 1);
  localparam logic [IDX_W-1:0] ROW_MAX  = IDX_W'(NUM_ROWS - 1);
  localparam logic [PH_W-1:0]  CPH_MAX  = PH_W'(POOL_W - 1);
  localparam logic [PH_W-1:0]  RPH_MAX  = PH_W'(POOL_H - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1'b1);
  localparam logic             CEIL_EN  = (CEIL_MODE != 0);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] col_idx_r;
  logic [IDX_W-1:0] row_idx_r;
  logic [PH_W-1:0]  col_phase_r;
  logic [PH_W-1:0]  row_phase_r;
  logic             frame_done_r;
  logic             overrun_r;

  logic             accept_s;
  logic             col_last_s;
  logic             row_last_s;
  logic             col_ph_last_s;
  logic             row_ph_last_s;
  logic             col_final_s;
  logic             row_final_s;

  // A pixel is only tagged when it is really accepted: running, and not
  // being discarded by a reset or frame restart on the same edge.
  assign accept_s      = En & (state_r == ST_RUN) & ~Rst & ~Clear;
  // Greater-or-equal keeps the counters inside their bounds even if a
  // register were ever disturbed into an out-of-range value.
  assign col_last_s    = (col_idx_r >= COL_MAX);
  assign row_last_s    = (row_idx_r >= ROW_MAX);
  assign col_ph_last_s = (col_phase_r >= CPH_MAX);
  assign row_ph_last_s = (row_phase_r >= RPH_MAX);

  // In ceil mode a partial window at the right or bottom edge also closes.
  assign col_final_s = (col_phase_r == CPH_MAX) | (CEIL_EN & (col_idx_r == COL_MAX));
  assign row_final_s = (row_phase_r == RPH_MAX) | (CEIL_EN & (row_idx_r == ROW_MAX));

  assign Win_First = accept_s & (col_phase_r == PH_ZERO) & (row_phase_r == PH_ZERO);
  assign Win_Last  = accept_s & col_final_s & row_final_s;

  assign Col_Idx    = col_idx_r;
  assign Row_Idx    = row_idx_r;
  assign Col_Phase  = col_phase_r;
  assign Row_Phase  = row_phase_r;
  assign Frame_Done = frame_done_r;
  assign Overrun    = overrun_r;

  // Frame state machine: advance the raster position per accepted pixel.
  always_ff @(posedge Clk) begin
    if (Rst || Clear) begin
      state_r      <= ST_RUN;
      col_idx_r    <= IDX_ZERO;
      row_idx_r    <= IDX_ZERO;
      col_phase_r  <= PH_ZERO;
      row_phase_r  <= PH_ZERO;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (En) begin
            if (col_last_s) begin
              col_idx_r   <= IDX_ZERO;
              col_phase_r <= PH_ZERO;
              if (row_last_s) begin
                row_idx_r    <= IDX_ZERO;
                row_phase_r  <= PH_ZERO;
                state_r      <= ST_DONE;
                frame_done_r <= 1'b1;
              end else begin
                row_idx_r   <= row_idx_r + IDX_ONE;
                row_phase_r <= row_ph_last_s ? PH_ZERO : (row_phase_r + PH_ONE);
              end
            end else begin
              col_idx_r   <= col_idx_r + IDX_ONE;
              col_phase_r <= col_ph_last_s ? PH_ZERO : (col_phase_r + PH_ONE);
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // Counters stay parked at zero; extra pixels only raise the flag.
          if (En) begin
            overrun_r <= 1'b1;
          end else begin
            overrun_r <= overrun_r;
          end
        end
        default: begin
          state_r      <= ST_RUN;
          col_idx_r    <= IDX_ZERO;
          row_idx_r    <= IDX_ZERO;
          col_phase_r  <= PH_ZERO;
          row_phase_r  <= PH_ZERO;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/maxpool_window_tracker.md
# maxpool_window_tracker

Parametrised position tracker for the max-pooling stage of a layer. It counts accepted pixels of a raster-scanned feature map and reports the column and row index of each pixel, its phase inside the pooling window, and a same-cycle tag when the pixel closes a window. It replaces a fixed 100-pixel row-parity counter with a configurable window size and frame geometry, an optional ceil mode, a frame-done state and overrun detection. It sits beside the maxpool compare/accumulate datapath and drives that datapath's window-reset and output-write strobes.

## Interface
- ROW_LEN, 100: pixels per row (≥1).
- NUM_ROWS, 100: rows per frame (≥1).
- POOL_W, 2: window width (1..ROW_LEN).
- POOL_H, 2: window height (1..NUM_ROWS).
- CEIL_MODE, 0: 0 drops partial windows; 1 closes partial windows at the row/frame edge.
- IDX_W, 7: width of index outputs (must hold max(ROW_LEN, NUM_ROWS)-1).
- PH_W, 1: width of phase outputs (must hold max(POOL_W, POOL_H)-1).
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous reset, active-high.
- En  in  1  pixel-accept strobe; one pixel per cycle when high.
- Clear  in  1  synchronous frame restart; same effect as Rst.
- Col_Idx  out  IDX_W  column of the pixel presented this cycle.
- Row_Idx  out  IDX_W  row of the pixel presented this cycle.
- Col_Phase  out  PH_W  Col_Idx mod POOL_W.
- Row_Phase  out  PH_W  Row_Idx mod POOL_H.
- Win_First  out  1  pixel opens a window: En, Col_Phase==0, Row_Phase==0.
- Win_Last  out  1  pixel closes a window (rules below).
- Frame_Done  out  1  registered; all NUM_ROWS×ROW_LEN pixels accepted.
- Overrun  out  1  registered, sticky; En seen while Frame_Done.

## Operation
- States: RUN, DONE. Rst/Clear → RUN with all counters 0.
- Col_Idx, Row_Idx, Col_Phase and Row_Phase are registers holding the position of the next pixel. Win_First and Win_Last are combinational from those registers and En.
- RUN, En=1: Col_Idx increments. Col_Phase increments and wraps at POOL_W. At Col_Idx==ROW_LEN-1 both wrap to 0 and the row advances: Row_Idx increments, Row_Phase increments and wraps at POOL_H.
- RUN, En=1 on pixel (NUM_ROWS-1, ROW_LEN-1): all counters wrap to 0 and the block enters DONE.
- RUN, En=0: all state holds.
- DONE: Frame_Done=1 and counters hold at 0. En is ignored except that Overrun is set. Leave DONE only via Rst or Clear.
- Win_Last requires En=1 and state RUN. With CEIL_MODE=0 it asserts when Col_Phase==POOL_W-1 and Row_Phase==POOL_H-1; trailing columns/rows that do not fill a window never assert it.
- Win_Last with CEIL_MODE=1:
  - column-final means Col_Phase==POOL_W-1 or Col_Idx==ROW_LEN-1;
  - row-final means Row_Phase==POOL_H-1 or Row_Idx==NUM_ROWS-1;
  - Win_Last = column-final and row-final.
- Row_Phase[0] equals the legacy row-parity signal when POOL_H=2 and ROW_LEN=100.
- Counter arithmetic is unsigned with explicit compare-and-wrap only. No division or modulo operators. Index and phase registers never exceed their parameter bounds.

## Timing
- Reset values: Col_Idx=0, Row_Idx=0, Col_Phase=0, Row_Phase=0, Frame_Done=0, Overrun=0, state RUN. Win_First and Win_Last are 0 when En=0.
- Win_First and Win_Last have 0 latency: valid in the same cycle as the En pixel they tag.
- Index and phase outputs update on the edge after an En cycle.
- Frame_Done rises on the edge that accepts the final pixel. Win_Last for that final pixel is asserted in the accept cycle, while Frame_Done is still 0.
- Overrun rises on the edge after the first En cycle in DONE.
- Priority on each edge: Rst, then Clear, then En. If Clear and En are both high, the pixel is dropped and counters go to 0.
- Rst or Clear mid-frame discards the partial frame with no Win_Last emitted.

## Test plan
- ROW_LEN=4, NUM_ROWS=4, POOL 2×2, CEIL_MODE=0: 16 consecutive En cycles.
  - Win_Last on pixels 5, 7, 13, 15 (0-based raster order).
  - Win_First on pixels 0, 2, 8, 10.
  - Frame_Done=1 after pixel 15.
- Default parameters with gapped En (1 of every 3 cycles): Row_Phase toggles after every 100 accepted pixels, and Frame_Done rises after 10000 accepted pixels.
- ROW_LEN=5, NUM_ROWS=3, POOL 2×2:
  - CEIL_MODE=0: Win_Last only on pixels 6 and 8.
  - CEIL_MODE=1: Win_Last on pixels 6, 8, 9, 11, 13, 14.
- After Frame_Done, apply 3 En pulses: Overrun=1, counters stay 0, no Win_Last. Then Clear: Frame_Done=0, Overrun=0.
- Clear asserted together with En at pixel 7 of a 4×4 frame: that pixel is dropped and Col_Idx=0, Row_Idx=0 on the next cycle. Rst mid-frame gives the same result and all outputs return to their reset values.
